ofm_packer: RTL and testbench
=============================

// Module: ofm_packer
// PURPOSE
//   Output-side counterpart of the input demux: takes one OFM result vector
//   (PE_array_size signed 8-bit elements from RELU/pool via OFM buffer) and
//   serialises it onto the single 32-bit accelerator output stream, four
//   elements per word, with valid/ready handshakes on both sides.
// PARAMETERS
//   OUTPUT_WIDTH      32  output stream word width (multiple of ofm_output_width)
//   ofm_output_width   8  width of one OFM element
//   PE_array_size      9  elements per input vector
//   (derived) LANES  = OUTPUT_WIDTH/ofm_output_width = 4
//   (derived) NWORDS = ceil(PE_array_size/LANES) = 3
// PORTS
//   clk        in   1    clock, all logic on rising edge
//   rst_n      in   1    synchronous reset, ACTIVE-HIGH (codebase port name kept)
//   ofm_valid  in   1    ofm_data/ofm_last valid
//   ofm_ready  out  1    packer accepts vector this cycle
//   ofm_data   in   PE_array_size*ofm_output_width  element i at [i*8 +: 8]
//   ofm_last   in   1    vector is the last of the layer
//   out_valid  out  1    out_data valid
//   out_ready  in   1    downstream accepts word
//   out_data   out  OUTPUT_WIDTH  packed word
//   out_last   out  1    final word of a vector flagged ofm_last
//   word_count out  16   words transferred since reset, wraps at 0xFFFF->0
// BEHAVIOUR
//   Reset (rst_n=1 at edge): state=IDLE, holding reg=0, idx=0, out_valid=0,
//     out_data=0, out_last=0, word_count=0; ofm_ready=0 while rst_n=1.
//   FSM IDLE: ofm_ready=1, out_valid=0. ofm_valid&&ofm_ready -> latch
//     ofm_data/ofm_last into holding reg, idx=0, go SEND.
//   FSM SEND: out_valid=1; out_data lane k (bits [k*8 +: 8]) = element idx*LANES+k;
//     lanes past PE_array_size are 0 (zero pad, never sign-extended);
//     elements copied raw, no arithmetic. out_last = held_last && idx==NWORDS-1.
//   Word handshake: out_valid&&out_ready -> idx++, word_count++.
//     On idx==NWORDS-1 handshake: if ofm_valid -> latch new vector, idx=0,
//     stay SEND (no bubble); else go IDLE.
//   ofm_ready = !rst_n && (state==IDLE || (idx==NWORDS-1 && out_ready)).
//   Latency: vector accepted at edge N -> first word valid after edge N.
//     Throughput: one vector per NWORDS cycles at full out_ready.
//   Backpressure: while out_valid && !out_ready, out_data/out_last held stable,
//     holding reg unchanged, ofm_ready=0.
//   out_valid never drops without a handshake, except on reset.
//   Reset mid-SEND: pending words dropped, out_valid=0 next cycle, FSM to IDLE.
//   ofm_valid while ofm_ready=0: ignored, upstream must hold.
// TESTING
//   1 Reset: rst_n=1 3 cycles -> out_valid=0, out_data=0, word_count=0, ofm_ready=0;
//     release -> ofm_ready=1.
//   2 Vector 0x01..0x09, ofm_last=1, out_ready=1 -> 0x04030201, 0x08070605,
//     0x00000009 on 3 consecutive cycles; out_last only on 3rd; word_count=3.
//   3 Same vector, out_ready=0 for 5 cycles at word 2 -> out_data=0x08070605
//     stable, ofm_ready=0; resumes, 3rd word next after handshake.
//   4 Two vectors back-to-back, ofm_valid held, out_ready=1 -> 6 words in 6
//     consecutive cycles, ofm_ready=1 on 3rd-word cycle only.
//   5 Elements all 0xFF (-1) -> 0xFFFFFFFF, 0xFFFFFFFF, 0x000000FF (pad zero).
//   6 rst_n=1 after 1st word accepted -> next cycle out_valid=0, word_count=0,
//     no further words; new vector afterwards restarts at lane 0 word.

Source files
------------

// File: rtl/ofm_packer_if.sv
// Handshake bundle for ofm_packer: OFM vector input stream, packed word output stream
// and the running word counter.
interface ofm_packer_if #(
    parameter int unsigned InW  = 72,
    parameter int unsigned OutW = 32
);
    logic            ofm_valid;
    logic            ofm_ready;
    logic [InW-1:0]  ofm_data;
    logic            ofm_last;
    logic            out_valid;
    logic            out_ready;
    logic [OutW-1:0] out_data;
    logic            out_last;
    logic [15:0]     word_count;

    // Packer side.
    modport master (
        input  ofm_valid, ofm_data, ofm_last, out_ready,
        output ofm_ready, out_valid, out_data, out_last, word_count
    );

    // Environment side: vector producer and word consumer.
    modport slave (
        output ofm_valid, ofm_data, ofm_last, out_ready,
        input  ofm_ready, out_valid, out_data, out_last, word_count
    );
endinterface

// File: rtl/ofm_packer.sv
// Serialises one OFM result vector onto the 32-bit output stream, LANES elements per word,
// zero-padding the tail word, with valid/ready on both sides and no bubble between vectors.
module ofm_packer #(
    parameter int unsigned OUTPUT_WIDTH     = 32,
    parameter int unsigned ofm_output_width = 8,
    parameter int unsigned PE_array_size    = 9
) (
    input  logic         clk,
    input  logic         rst_n,  // active-high synchronous reset despite the name
    ofm_packer_if.master bus
);

    localparam int unsigned Lanes  = OUTPUT_WIDTH / ofm_output_width;
    localparam int unsigned NWords = (PE_array_size + Lanes - 1) / Lanes;
    localparam int unsigned VecW   = PE_array_size * ofm_output_width;
    localparam int unsigned PadW   = NWords * OUTPUT_WIDTH;
    localparam int unsigned IdxW   = (NWords > 1) ? $clog2(NWords) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [VecW-1:0]   hold_q, hold_d;
    logic              last_q, last_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [15:0]       wc_q, wc_d;

    logic              sending;
    logic              last_word;
    logic              ofm_ready;
    logic              accept;
    logic              word_hs;
    logic [PadW-1:0]   hold_pad;
    logic [OUTPUT_WIDTH-1:0] out_data;

    assign sending   = (state_q == StSend);
    assign last_word = sending && (idx_q == LastIdx);
    assign ofm_ready = !rst_n && ((state_q == StIdle) || (last_word && bus.out_ready));
    assign accept    = bus.ofm_valid && ofm_ready;
    assign word_hs   = sending && bus.out_ready;

    // Lanes beyond the last element come from the zero extension, never from sign bits.
    assign hold_pad = PadW'(hold_q);

    always_comb begin
        out_data = '0;
        if (sending) begin
            out_data = hold_pad[32'(idx_q) * OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_d  = bus.ofm_data;
                    last_d  = bus.ofm_last;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (word_hs) begin
                    wc_d = wc_q + 16'd1;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        // Back-to-back vectors reload here so the stream has no idle cycle.
                        if (accept) begin
                            hold_d = bus.ofm_data;
                            last_d = bus.ofm_last;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
        end
    end

    assign bus.ofm_ready  = ofm_ready;
    assign bus.out_valid  = sending;
    assign bus.out_data   = out_data;
    assign bus.out_last   = last_word && last_q;
    assign bus.word_count = wc_q;

endmodule

// File: tb/tb_ofm_packer.sv
// Directed and randomized bench for ofm_packer; expected words come from a queue-based
// model that slices each accepted vector into zero-padded 4-element words.
module tb_ofm_packer;

    localparam int unsigned NElem  = 9;
    localparam int unsigned NLanes = 4;
    localparam int unsigned NWrd   = 3;
    localparam int unsigned NRand  = 40;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ofm_packer_if #(.InW(72), .OutW(32)) bus ();

    ofm_packer #(
        .OUTPUT_WIDTH    (32),
        .ofm_output_width(8),
        .PE_array_size   (9)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [71:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < NLanes; k++) begin
            int e;
            e = w * NLanes + k;
            if (e < NElem) r[k*8 +: 8] = v[e*8 +: 8];
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [71:0] v;
        logic [71:0] va;
        logic [71:0] vb;
        logic [15:0] wc_m;
        logic [31:0] exp_q[$];
        logic        exp_l[$];
        logic [71:0] cur;
        logic        cur_last;
        bit          pres;
        bit          prev_stall;
        logic [31:0] prev_data;
        int          sent;
        int          cycles;

        checks = 0;
        errors = 0;
        wc_m   = '0;

        // Reset held three cycles
        rst_n = 1'b1;
        bus.ofm_valid = 1'b0;
        bus.ofm_data  = '0;
        bus.ofm_last  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) cyc();
        chk1 ("rst_out_valid", bus.out_valid, 1'b0);
        chk32("rst_out_data", bus.out_data, 32'h0);
        chk32("rst_word_count", 32'(bus.word_count), 32'h0);
        chk1 ("rst_ofm_ready", bus.ofm_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1 ("rel_ofm_ready", bus.ofm_ready, 1'b1);

        // Basic vector, full-rate drain
        v = 72'h09_08_07_06_05_04_03_02_01;
        bus.ofm_data  = v;
        bus.ofm_last  = 1'b1;
        bus.ofm_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        cyc();
        bus.ofm_valid = 1'b0;
        #1;
        chk32("t2_w0", bus.out_data, 32'h04030201);
        chk1 ("t2_w0_valid", bus.out_valid, 1'b1);
        chk1 ("t2_w0_last", bus.out_last, 1'b0);
        cyc();
        chk32("t2_w1", bus.out_data, 32'h08070605);
        chk1 ("t2_w1_last", bus.out_last, 1'b0);
        cyc();
        chk32("t2_w2", bus.out_data, 32'h00000009);
        chk1 ("t2_w2_last", bus.out_last, 1'b1);
        chk1 ("t2_w2_ofm_ready", bus.ofm_ready, 1'b1);
        cyc();
        wc_m = 16'd3;
        chk1 ("t2_idle_valid", bus.out_valid, 1'b0);
        chk32("t2_word_count", 32'(bus.word_count), 32'(wc_m));

        // Backpressure on the second word
        bus.ofm_valid = 1'b1;
        #1;
        cyc();
        bus.ofm_valid = 1'b0;
        #1;
        chk32("t3_w0", bus.out_data, model_word(v, 0));
        cyc();
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk32("t3_stall_data", bus.out_data, 32'h08070605);
            chk1 ("t3_stall_valid", bus.out_valid, 1'b1);
            chk1 ("t3_stall_ofm_ready", bus.ofm_ready, 1'b0);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk32("t3_resume_w1", bus.out_data, 32'h08070605);
        cyc();
        chk32("t3_w2", bus.out_data, 32'h00000009);
        chk1 ("t3_w2_last", bus.out_last, 1'b1);
        cyc();
        wc_m = 16'd6;
        chk32("t3_word_count", 32'(bus.word_count), 32'(wc_m));

        // Two vectors back to back with ofm_valid held
        va = 72'({$urandom(), $urandom(), $urandom()});
        vb = 72'({$urandom(), $urandom(), $urandom()});
        bus.ofm_data  = va;
        bus.ofm_last  = 1'b0;
        bus.ofm_valid = 1'b1;
        #1;
        chk1("t4_accept_a", bus.ofm_ready, 1'b1);
        cyc();
        bus.ofm_data = vb;
        bus.ofm_last = 1'b1;
        #1;
        for (int w = 0; w < NWrd; w++) begin
            chk32("t4_a_word", bus.out_data, model_word(va, w));
            chk1 ("t4_a_last", bus.out_last, 1'b0);
            chk1 ("t4_a_ofm_ready", bus.ofm_ready, w == NWrd - 1);
            cyc();
        end
        bus.ofm_valid = 1'b0;
        #1;
        for (int w = 0; w < NWrd; w++) begin
            chk1 ("t4_b_valid", bus.out_valid, 1'b1);
            chk32("t4_b_word", bus.out_data, model_word(vb, w));
            chk1 ("t4_b_last", bus.out_last, w == NWrd - 1);
            chk1 ("t4_b_ofm_ready", bus.ofm_ready, w == NWrd - 1);
            cyc();
        end
        wc_m = 16'd12;
        chk1 ("t4_idle_valid", bus.out_valid, 1'b0);
        chk32("t4_word_count", 32'(bus.word_count), 32'(wc_m));

        // All -1 elements: tail lanes must be zero, not sign-filled
        bus.ofm_data  = {9{8'hFF}};
        bus.ofm_last  = 1'b0;
        bus.ofm_valid = 1'b1;
        #1;
        cyc();
        bus.ofm_valid = 1'b0;
        #1;
        chk32("t5_w0", bus.out_data, 32'hFFFFFFFF);
        cyc();
        chk32("t5_w1", bus.out_data, 32'hFFFFFFFF);
        cyc();
        chk32("t5_w2", bus.out_data, 32'h000000FF);
        chk1 ("t5_w2_last", bus.out_last, 1'b0);
        cyc();
        wc_m = 16'd15;

        // Reset mid-vector after the first word
        v = 72'({$urandom(), $urandom(), $urandom()});
        bus.ofm_data  = v;
        bus.ofm_last  = 1'b1;
        bus.ofm_valid = 1'b1;
        #1;
        cyc();
        bus.ofm_valid = 1'b0;
        #1;
        chk32("t6_w0", bus.out_data, model_word(v, 0));
        cyc();
        rst_n = 1'b1;
        #1;
        chk1("t6_rst_ofm_ready", bus.ofm_ready, 1'b0);
        cyc();
        rst_n = 1'b0;
        wc_m  = '0;
        #1;
        chk1 ("t6_drop_valid", bus.out_valid, 1'b0);
        chk32("t6_word_count", 32'(bus.word_count), 32'h0);
        cyc();
        chk1 ("t6_no_more_words", bus.out_valid, 1'b0);
        vb = 72'({$urandom(), $urandom(), $urandom()});
        bus.ofm_data  = vb;
        bus.ofm_valid = 1'b1;
        #1;
        cyc();
        bus.ofm_valid = 1'b0;
        #1;
        for (int w = 0; w < NWrd; w++) begin
            chk32("t6_restart_word", bus.out_data, model_word(vb, w));
            cyc();
        end
        wc_m = 16'd3;
        chk32("t6_restart_count", 32'(bus.word_count), 32'(wc_m));

        // Random traffic against the word-queue model
        pres       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        sent       = 0;
        cycles     = 0;
        cur        = '0;
        cur_last   = 1'b0;
        while (!(sent == NRand && exp_q.size() == 0) && cycles < 3000) begin
            if (!pres && sent < NRand && $urandom_range(3) != 0) begin
                cur      = 72'({$urandom(), $urandom(), $urandom()});
                cur_last = 1'($urandom_range(1));
                pres     = 1'b1;
            end
            bus.ofm_valid = pres;
            bus.ofm_data  = cur;
            bus.ofm_last  = cur_last;
            bus.out_ready = ($urandom_range(9) < 7);
            #1;
            chk1("rnd_ofm_ready", bus.ofm_ready,
                 (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready));
            chk1("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk32("rnd_out_data", bus.out_data, exp_q[0]);
                chk1 ("rnd_out_last", bus.out_last, exp_l[0]);
                if (prev_stall) chk32("rnd_stall_stable", bus.out_data, prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(exp_l.pop_front());
                wc_m = wc_m + 16'd1;
            end
            if (bus.ofm_valid && bus.ofm_ready) begin
                for (int w = 0; w < NWrd; w++) begin
                    exp_q.push_back(model_word(cur, w));
                    exp_l.push_back(cur_last && (w == NWrd - 1));
                end
                pres = 1'b0;
                sent++;
            end
            cyc();
            cycles++;
        end
        chk1 ("rnd_completed", (sent == NRand) && (exp_q.size() == 0), 1'b1);
        chk32("rnd_word_count", 32'(bus.word_count), 32'(wc_m));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
